hack_writeback: RTL and testbench

Commit stage of the Hack CPU, directly downstream of the ALU. It holds the architectural A and D registers and the program counter, and feeds A and D back to the ALU. Each accepted instruction is committed in one cycle: A-instructions load A, C-instructions write the ALU result to A, D and/or memory and evaluate the jump condition. Memory writes go out over a valid/ready handshake that stalls instruction acceptance until the write completes.

---
 rtl/hack_pkg.sv | 36 +++
 rtl/hack_jump_unit.sv | 15 +
 rtl/hack_writeback.sv | 87 ++++++++
 tb/tb_hack_writeback.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU pipeline stages.
// Instruction bit positions, commit-stage state and field decode.
package hack_pkg;

  localparam int INSTR_IS_C = 15;
  localparam int DEST_A     = 5;
  localparam int DEST_D     = 4;
  localparam int DEST_M     = 3;
  localparam int JMP_LT     = 2;
  localparam int JMP_EQ     = 1;
  localparam int JMP_GT     = 0;

  typedef enum logic {
    RUN,
    WAIT
  } wb_state_t;

  typedef struct packed {
    logic       is_c;
    logic       da;
    logic       dd;
    logic       dm;
    logic [2:0] jmp;
  } wb_dec_t;

  function automatic wb_dec_t wb_decode(input logic [15:0] i);
    wb_dec_t d;
    d.is_c = i[INSTR_IS_C];
    d.da   = i[DEST_A];
    d.dd   = i[DEST_D];
    d.dm   = i[DEST_M];
    d.jmp  = {i[JMP_LT], i[JMP_EQ], i[JMP_GT]};
    return d;
  endfunction

endpackage

// File: rtl/hack_jump_unit.sv
// Hack jump condition evaluation from ALU sign and zero flags.
// Shared with the fetch stage.
module hack_jump_unit (
  input  logic [2:0] jmp,
  input  logic       neg,
  input  logic       zero,
  output logic       take
);

  logic gt;

  assign gt   = !neg && !zero;
  assign take = (jmp[2] & neg) | (jmp[1] & zero) | (jmp[0] & gt);

endmodule

// File: rtl/hack_writeback.sv
// Hack CPU commit stage: A/D/pc registers, jump resolution,
// and the single outstanding memory write handshake.
module hack_writeback #(
  parameter int WIDTH    = 16,
  parameter int PC_WIDTH = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    instruction,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [WIDTH-1:0]    result,
  input  logic                zero,
  output logic [WIDTH-1:0]    A,
  output logic [WIDTH-1:0]    D,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  output logic                mem_wr_valid,
  input  logic                mem_wr_ready
);

  import hack_pkg::*;

  wb_state_t           state;
  wb_dec_t             dec;
  logic                take;
  logic                accept;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] a_lo;

  assign dec    = wb_decode(instruction[15:0]);
  assign a_lo   = A[PC_WIDTH-1:0];
  assign pc_inc = pc + 1'b1;

  // Held low during reset so nothing is accepted until release.
  assign instr_ready = (state == RUN) && !reset;
  assign accept      = instr_valid && instr_ready;

  hack_jump_unit u_jump (
    .jmp  (dec.jmp),
    .neg  (result[WIDTH-1]),
    .zero (zero),
    .take (take)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= RUN;
      A            <= '0;
      D            <= '0;
      pc           <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wr_valid <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (accept) begin
            if (!dec.is_c) begin
              A  <= WIDTH'(instruction[PC_WIDTH-1:0]);
              pc <= pc_inc;
            end else begin
              if (dec.da) A <= result;
              if (dec.dd) D <= result;
              if (dec.dm) begin
                mem_addr     <= a_lo;
                mem_wdata    <= result;
                mem_wr_valid <= 1'b1;
                state        <= WAIT;
              end
              pc <= take ? a_lo : pc_inc;
            end
          end
        end
        WAIT: begin
          if (mem_wr_ready) begin
            mem_wr_valid <= 1'b0;
            state        <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_writeback.sv
// Directed bench for hack_writeback: vector table for
// single-cycle commits plus write-stall, reset and valid sequences.
module tb_hack_writeback;

  logic        clk;
  logic        reset;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] result;
  logic        zero;
  logic [15:0] A;
  logic [15:0] D;
  logic [14:0] pc;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_wr_valid;
  logic        mem_wr_ready;

  int n_checks;
  int n_fail;

  hack_writeback #(.WIDTH(16), .PC_WIDTH(15)) dut (
    .clk          (clk),
    .reset        (reset),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .result       (result),
    .zero         (zero),
    .A            (A),
    .D            (D),
    .pc           (pc),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wr_valid (mem_wr_valid),
    .mem_wr_ready (mem_wr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] res;
    logic        z;
    logic [15:0] ea;
    logic [15:0] ed;
    logic [14:0] epc;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] i, input logic [15:0] r,
                       input logic z, input logic v);
    instruction = i;
    result      = r;
    zero        = z;
    instr_valid = v;
  endtask

  task automatic check_arch(input string tag, input logic [15:0] ea,
                            input logic [15:0] ed, input logic [14:0] epc,
                            input logic ewv);
    check({tag, ".A"}, 32'(A), 32'(ea));
    check({tag, ".D"}, 32'(D), 32'(ed));
    check({tag, ".pc"}, 32'(pc), 32'(epc));
    check({tag, ".wv"}, 32'(mem_wr_valid), 32'(ewv));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = '{16'h1234, 16'h0000, 1'b0, 16'h1234, 16'h0000, 15'h0001};
    vecs[1]  = '{16'hE010, 16'h1234, 1'b0, 16'h1234, 16'h1234, 15'h0002};
    vecs[2]  = '{16'h0040, 16'h0000, 1'b0, 16'h0040, 16'h1234, 15'h0003};
    vecs[3]  = '{16'hE004, 16'h8000, 1'b0, 16'h0040, 16'h1234, 15'h0040};
    vecs[4]  = '{16'hE002, 16'h0000, 1'b1, 16'h0040, 16'h1234, 15'h0040};
    vecs[5]  = '{16'hE001, 16'h0000, 1'b1, 16'h0040, 16'h1234, 15'h0041};
    vecs[6]  = '{16'hE007, 16'h0005, 1'b0, 16'h0040, 16'h1234, 15'h0040};
    vecs[7]  = '{16'hE001, 16'h0005, 1'b0, 16'h0040, 16'h1234, 15'h0040};
    vecs[8]  = '{16'hE004, 16'h0005, 1'b0, 16'h0040, 16'h1234, 15'h0041};
    vecs[9]  = '{16'hE030, 16'h7FFF, 1'b0, 16'h7FFF, 16'h7FFF, 15'h0042};
    vecs[10] = '{16'hE007, 16'h0000, 1'b1, 16'h7FFF, 16'h7FFF, 15'h7FFF};
    vecs[11] = '{16'h0005, 16'h0000, 1'b0, 16'h0005, 16'h7FFF, 15'h0000};
    vecs[12] = '{16'hE020, 16'hFFFF, 1'b0, 16'hFFFF, 16'h7FFF, 15'h0001};
    vecs[13] = '{16'hE007, 16'h0001, 1'b0, 16'hFFFF, 16'h7FFF, 15'h7FFF};
    vecs[14] = '{16'hE000, 16'h1111, 1'b0, 16'hFFFF, 16'h7FFF, 15'h0000};
    vecs[15] = '{16'h0010, 16'h0000, 1'b0, 16'h0010, 16'h7FFF, 15'h0001};

    reset        = 1'b1;
    mem_wr_ready = 1'b0;
    drive(16'h0000, 16'h0000, 1'b0, 1'b0);
    #12;
    check_arch("rst", 16'h0000, 16'h0000, 15'h0000, 1'b0);
    check("rst.ready", 32'(instr_ready), 32'h0);
    reset = 1'b0;
    #1;
    check("post_rst.ready", 32'(instr_ready), 32'h1);

    // Single-cycle commits, one per cycle with no bubbles.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].instr, vecs[i].res, vecs[i].z, 1'b1);
      tick();
      check_arch($sformatf("vec%0d", i), vecs[i].ea, vecs[i].ed,
                 vecs[i].epc, 1'b0);
      check($sformatf("vec%0d.ready", i), 32'(instr_ready), 32'h1);
    end

    // AMD=... with memory stalled for three cycles.
    drive(16'hE038, 16'h00FF, 1'b0, 1'b1);
    tick();
    drive(16'h0AAA, 16'h0000, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      check_arch($sformatf("wait%0d", c), 16'h00FF, 16'h00FF,
                 15'h0002, 1'b1);
      check($sformatf("wait%0d.addr", c), 32'(mem_addr), 32'h0010);
      check($sformatf("wait%0d.data", c), 32'(mem_wdata), 32'h00FF);
      check($sformatf("wait%0d.ready", c), 32'(instr_ready), 32'h0);
      if (c == 3) mem_wr_ready = 1'b1;
      else tick();
    end
    tick();
    mem_wr_ready = 1'b0;
    check_arch("done", 16'h00FF, 16'h00FF, 15'h0002, 1'b0);
    check("done.ready", 32'(instr_ready), 32'h1);
    tick();
    check_arch("after_wr", 16'h0AAA, 16'h00FF, 15'h0003, 1'b0);

    // Reset asserted between edges while a write is pending.
    drive(16'hE008, 16'h0ABC, 1'b0, 1'b1);
    tick();
    check_arch("mw", 16'h0AAA, 16'h00FF, 15'h0004, 1'b1);
    check("mw.addr", 32'(mem_addr), 32'h0AAA);
    check("mw.data", 32'(mem_wdata), 32'h0ABC);
    drive(16'h0033, 16'h0000, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_arch("midrst", 16'h0000, 16'h0000, 15'h0000, 1'b0);
    check("midrst.ready", 32'(instr_ready), 32'h0);
    tick();
    check_arch("rst_edge", 16'h0000, 16'h0000, 15'h0000, 1'b0);
    reset = 1'b0;
    tick();
    check_arch("first", 16'h0033, 16'h0000, 15'h0001, 1'b0);

    // Valid toggling 1,0,1; stray mem_wr_ready must be ignored.
    mem_wr_ready = 1'b1;
    drive(16'hE010, 16'h0042, 1'b0, 1'b1);
    tick();
    check_arch("tog0", 16'h0033, 16'h0042, 15'h0002, 1'b0);
    drive(16'hE038, 16'h9999, 1'b0, 1'b0);
    tick();
    check_arch("tog1", 16'h0033, 16'h0042, 15'h0002, 1'b0);
    check("tog1.ready", 32'(instr_ready), 32'h1);
    drive(16'h0007, 16'h0000, 1'b0, 1'b1);
    tick();
    check_arch("tog2", 16'h0007, 16'h0042, 15'h0003, 1'b0);
    instr_valid  = 1'b0;
    mem_wr_ready = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
